mem_test_ctrl: RTL and testbench
================================

Name: mem_test_ctrl

Overview:
Parametrised memory built-in self-test engine. It sits between the ISSP/control plane and one frame-buffer memory port (wr_*/rd_* handshake into the RAM interface). It writes a programmable region with a selectable pattern, reads it back, and checks every returned word under a compare mask. It reports pass/fail, an error count and the first failing address.

Parameters:
AW, 24, address width in words
DW, 32, data width; legal range 8..32
TIMEOUT, 1024, idle cycles allowed in DRAIN with no rd_data_valid before a timeout is flagged
ERR_W, 16, width of the saturating error counter

Ports:
clk  in  1  single clock for all logic
reset  in  1  asynchronous, active-high; clears all state
start  in  1  single-cycle request to begin a test; ignored while busy
mode  in  2  pattern: 0 constant patt, 1 address, 2 inverted address, 3 LFSR seeded by patt
patt  in  DW  constant pattern / LFSR seed
cmp_mask  in  DW  bit set = compared bit
base_addr  in  AW  first word address
num_words  in  AW  words to test
wr_rdy  in  1  memory accepts a write this cycle
wr_en  out  1  write request
wr_addr  out  AW  write address
wr_data  out  DW  write data
rd_rdy  in  1  memory accepts a read this cycle
rd_en  out  1  read request
rd_addr  out  AW  read address
rd_data  in  DW  returned read data
rd_data_valid  in  1  rd_data valid; returns arrive in issue order
busy  out  1  test in progress
done  out  1  sticky; test finished
pass  out  1  sticky; finished with zero errors and no timeout
fail  out  1  sticky; at least one error or a timeout
timeout  out  1  sticky; DRAIN timed out
err_cnt  out  ERR_W  mismatching beats, saturating at all-ones
first_err_addr  out  AW  address of the first mismatch

Behaviour:
- Reset values: all outputs 0. FSM in IDLE. Internal counters and LFSRs cleared.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE, start=1:
  - Latch mode, patt, cmp_mask, base_addr and num_words.
  - Clear done, pass, fail, timeout, err_cnt and first_err_addr.
  - Go to WRITE next cycle; busy=1 from that cycle.
  - If num_words=0, go straight to DONE with pass=1.
- WRITE:
  - wr_en=1 continuously.
  - A beat is accepted when wr_en&wr_rdy. On acceptance, wr_addr increments and wr_data advances.
  - After num_words accepted beats, deassert wr_en in the following cycle and go to READ.
- READ:
  - Same handshake with rd_en/rd_rdy.
  - After num_words accepted requests, go to DRAIN.
- Checker:
  - Active in READ and DRAIN. It has its own index and pattern generator.
  - On each rd_data_valid, compare (rd_data^expected)&cmp_mask, then advance the index.
  - On a mismatch: err_cnt increments (saturating). If this is the first mismatch, first_err_addr = base_addr+index.
  - rd_data_valid in IDLE, WRITE or DONE is ignored.
- DRAIN:
  - Exits to DONE when checked beats = num_words.
  - A counter resets on every valid beat. When it reaches TIMEOUT, set timeout=1 and go to DONE.
- DONE:
  - busy=0, done=1.
  - fail = (err_cnt!=0)|timeout; pass = !fail.
  - Stays in DONE until the next start. That start behaves as IDLE+start.
- Addressing: address = base_addr+index modulo 2^AW; wraps silently past the top.
- Patterns, all taken in the low DW bits:
  - Mode 1: address zero-extended or truncated to DW.
  - Mode 2: its bitwise inverse.
  - Mode 3: 32-bit Galois LFSR, taps 0x80200003, seed = patt zero-extended. A seed of 0 is forced to 1. The LFSR steps once per accepted beat.
- Simultaneous events:
  - A valid beat in the same cycle that the timeout is reached counts as data; the timeout does not fire that cycle.
  - start while busy has no effect.
- Reset mid-test: an asynchronous abort. All outputs return to 0 immediately, and wr_en/rd_en drop without completing the handshake.

Decomposition:
- Package mem_test_pkg holds:
  - mode encodings MODE_CONST, MODE_ADDR, MODE_NADDR, MODE_LFSR
  - the FSM state encoding
  - LFSR_TAPS = 32'h80200003
- Sub-module mem_test_patgen, instantiated twice (write side and check side):
  - inputs: mode, seed, base, load, step
  - output: DW-bit pattern and the current address

Test Plan:
- mode=0, patt=24'hFFFFFF (zero-extended), cmp_mask=32'h00FFFFFF, base=0, num_words=503, ideal memory -> 503 writes then 503 reads; done=1, pass=1, err_cnt=0.
- mode=1, base=10, num_words=8; model corrupts word at address 13, bit 4 -> err_cnt=1, first_err_addr=13, fail=1. Repeat with cmp_mask bit 4 cleared -> pass=1.
- mode=3, seed=0, num_words=16, wr_rdy/rd_rdy random 50% -> LFSR sequence starts from seed 1; all handshakes honoured (no address advance while rdy=0); pass=1.
- base=24'hFFFFFE, num_words=4, mode=1 -> addresses FFFFFE, FFFFFF, 000000, 000001 written and read; pass=1.
- Model drops the last read return -> after TIMEOUT=1024 idle cycles: timeout=1, fail=1, done=1. Assert reset mid-WRITE in a second run -> wr_en=0 and all flags 0 in the same cycle.

Source files
------------

// File: rtl/mem_test_pkg.sv
// Shared encodings and LFSR helper for the memory self-test engine.
package mem_test_pkg;

  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_ADDR  = 2'd1,
    MODE_NADDR = 2'd2,
    MODE_LFSR  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/mem_test_patgen.sv
// Address/pattern generator: loads a start point, then advances one word per step.
module mem_test_patgen
  import mem_test_pkg::*;
#(
  parameter int unsigned AW = 24,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] seed,
  input  logic [AW-1:0] base,
  input  logic          load,
  input  logic          step,
  output logic [DW-1:0] pattern,
  output logic [AW-1:0] addr
);

  logic [1:0]    mode_q, mode_d;
  logic [DW-1:0] seed_q, seed_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   lfsr_q, lfsr_d;
  logic [DW-1:0] pat_q, pat_d;

  // Pattern for one word, taken from the low DW bits of its source.
  function automatic logic [DW-1:0] pat_of(input logic [1:0]    m,
                                           input logic [DW-1:0] s,
                                           input logic [AW-1:0] a,
                                           input logic [31:0]   l);
    logic [AW+DW-1:0] ax;
    ax = {{DW{1'b0}}, a};
    case (m)
      MODE_CONST: return s;
      MODE_ADDR:  return ax[DW-1:0];
      MODE_NADDR: return ~ax[DW-1:0];
      default:    return l[DW-1:0];
    endcase
  endfunction

  always_comb begin
    mode_d = mode_q;
    seed_d = seed_q;
    addr_d = addr_q;
    lfsr_d = lfsr_q;
    pat_d  = pat_q;
    if (load) begin
      mode_d = mode;
      seed_d = seed;
      addr_d = base;
      lfsr_d = (seed == '0) ? 32'd1 : 32'(seed);
      pat_d  = pat_of(mode, seed, base, lfsr_d);
    end else if (step) begin
      addr_d = addr_q + AW'(1);
      lfsr_d = lfsr_next(lfsr_q);
      pat_d  = pat_of(mode_q, seed_q, addr_d, lfsr_d);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= '0;
      seed_q <= '0;
      addr_q <= '0;
      lfsr_q <= '0;
      pat_q  <= '0;
    end else begin
      mode_q <= mode_d;
      seed_q <= seed_d;
      addr_q <= addr_d;
      lfsr_q <= lfsr_d;
      pat_q  <= pat_d;
    end
  end

  assign pattern = pat_q;
  assign addr    = addr_q;

endmodule

// File: rtl/mem_test_ctrl.sv
// Memory BIST engine: writes a region with a selectable pattern, reads it back
// and checks every returned word under a compare mask.
module mem_test_ctrl
  import mem_test_pkg::*;
#(
  parameter int unsigned AW      = 24,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned ERR_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [DW-1:0]    patt,
  input  logic [DW-1:0]    cmp_mask,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW-1:0]    num_words,
  input  logic             wr_rdy,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [DW-1:0]    wr_data,
  input  logic             rd_rdy,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  input  logic [DW-1:0]    rd_data,
  input  logic             rd_data_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [ERR_W-1:0] err_cnt,
  output logic [AW-1:0]    first_err_addr
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             wr_en_q, wr_en_d;
  logic             rd_en_q, rd_en_d;
  logic [AW-1:0]    num_q, num_d;
  logic [DW-1:0]    mask_q, mask_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic [AW-1:0]    wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]    rd_cnt_q, rd_cnt_d;
  logic [AW-1:0]    chk_cnt_q, chk_cnt_d;
  logic [TW-1:0]    idle_q, idle_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [AW-1:0]    first_q, first_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             to_q, to_d;

  logic             start_ok;
  logic             wr_acc;
  logic             rd_acc;
  logic             chk_beat;
  logic             mismatch;
  logic [DW-1:0]    chk_pat;
  logic [AW-1:0]    chk_addr;

  assign start_ok = start && (state_q == IDLE || state_q == DONE);
  assign wr_acc   = wr_en_q && wr_rdy;
  assign rd_acc   = rd_en_q && rd_rdy;
  assign chk_beat = rd_data_valid && (state_q == READ || state_q == DRAIN);
  assign mismatch = |((rd_data ^ chk_pat) & mask_q);

  // Write side drives the memory write port directly.
  mem_test_patgen #(.AW(AW), .DW(DW)) u_wr_gen (
    .clk     (clk),
    .reset   (reset),
    .mode    (mode),
    .seed    (patt),
    .base    (base_addr),
    .load    (start_ok),
    .step    (wr_acc),
    .pattern (wr_data),
    .addr    (wr_addr)
  );

  // Check side replays the same sequence, one word per returned beat.
  mem_test_patgen #(.AW(AW), .DW(DW)) u_chk_gen (
    .clk     (clk),
    .reset   (reset),
    .mode    (mode),
    .seed    (patt),
    .base    (base_addr),
    .load    (start_ok),
    .step    (chk_beat),
    .pattern (chk_pat),
    .addr    (chk_addr)
  );

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    mask_d    = mask_q;
    rd_addr_d = rd_addr_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    chk_cnt_d = chk_cnt_q;
    idle_d    = idle_q;
    err_d     = err_q;
    first_d   = first_q;
    done_d    = done_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    to_d      = to_q;

    if (chk_beat) begin
      chk_cnt_d = chk_cnt_q + AW'(1);
      if (mismatch) begin
        if (err_q != '1) err_d = err_q + ERR_W'(1);
        if (err_q == '0) first_d = chk_addr;
      end
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          num_d     = num_words;
          mask_d    = cmp_mask;
          rd_addr_d = base_addr;
          wr_cnt_d  = '0;
          rd_cnt_d  = '0;
          chk_cnt_d = '0;
          idle_d    = '0;
          err_d     = '0;
          first_d   = '0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          to_d      = 1'b0;
          if (num_words == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (wr_acc) begin
          wr_cnt_d = wr_cnt_q + AW'(1);
          if (wr_cnt_d == num_q) state_d = READ;
        end
      end
      READ: begin
        if (rd_acc) begin
          rd_cnt_d  = rd_cnt_q + AW'(1);
          rd_addr_d = rd_addr_q + AW'(1);
          if (rd_cnt_d == num_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // A beat arriving on the timeout cycle wins over the timeout.
        idle_d = chk_beat ? '0 : idle_q + TW'(1);
        if (chk_cnt_d == num_q) begin
          state_d = DONE;
        end else if (!chk_beat && idle_d == TW'(TIMEOUT)) begin
          to_d    = 1'b1;
          state_d = DONE;
        end
        if (state_d == DONE) begin
          done_d = 1'b1;
          fail_d = (err_d != '0) || to_d;
          pass_d = !fail_d;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d == WRITE) || (state_d == READ) || (state_d == DRAIN);
    wr_en_d = (state_d == WRITE);
    rd_en_d = (state_d == READ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      num_q     <= '0;
      mask_q    <= '0;
      rd_addr_q <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      chk_cnt_q <= '0;
      idle_q    <= '0;
      err_q     <= '0;
      first_q   <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      num_q     <= num_d;
      mask_q    <= mask_d;
      rd_addr_q <= rd_addr_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      chk_cnt_q <= chk_cnt_d;
      idle_q    <= idle_d;
      err_q     <= err_d;
      first_q   <= first_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      to_q      <= to_d;
    end
  end

  assign busy           = busy_q;
  assign wr_en          = wr_en_q;
  assign rd_en          = rd_en_q;
  assign rd_addr        = rd_addr_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign fail           = fail_q;
  assign timeout        = to_q;
  assign err_cnt        = err_q;
  assign first_err_addr = first_q;

endmodule

// File: tb/tb_mem_test_ctrl.sv
// Bench for mem_test_ctrl: table of test runs against a 1-cycle-latency memory
// model, plus hand sequences for start-while-busy and reset mid-write.
module tb_mem_test_ctrl;

  localparam int unsigned AW = 24, DW = 32, TIMEOUT = 1024, ERR_W = 16;
  localparam int NV = 10;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       mode = '0;
  logic [DW-1:0]    patt = '0;
  logic [DW-1:0]    cmp_mask = '0;
  logic [AW-1:0]    base_addr = '0;
  logic [AW-1:0]    num_words = '0;
  logic             wr_rdy = 1'b0;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             rd_rdy = 1'b0;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [DW-1:0]    rd_data = '0;
  logic             rd_data_valid = 1'b0;
  logic             busy, done, pass, fail, timeout;
  logic [ERR_W-1:0] err_cnt;
  logic [AW-1:0]    first_err_addr;

  mem_test_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .ERR_W(ERR_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .mode           (mode),
    .patt           (patt),
    .cmp_mask       (cmp_mask),
    .base_addr      (base_addr),
    .num_words      (num_words),
    .wr_rdy         (wr_rdy),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .rd_rdy         (rd_rdy),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .rd_data_valid  (rd_data_valid),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail           (fail),
    .timeout        (timeout),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] patt;
    logic [31:0] mask;
    logic [23:0] base;
    logic [23:0] num;
    bit          rnd;
    bit          cor;
    bit          cor_all;
    logic [23:0] cor_addr;
    bit          drop;
    bit          e_pass;
    bit          e_fail;
    bit          e_to;
    logic [15:0] e_err;
    logic [23:0] e_first;
  } vec_t;

  vec_t vecs[NV];
  vec_t cfg;
  vec_t v;

  int checks = 0;
  int fails = 0;

  logic [31:0] mem [logic [23:0]];
  logic [23:0] rq[$];
  int          wr_n, rd_n, rtn_n;
  logic [31:0] m_lfsr;

  function automatic vec_t mk(input logic [1:0] m, input logic [31:0] p, input logic [31:0] k,
                              input logic [23:0] b, input logic [23:0] n, input bit rnd,
                              input bit cor, input bit cor_all, input logic [23:0] ca,
                              input bit drop, input bit ep, input bit ef, input bit et,
                              input logic [15:0] ee, input logic [23:0] efa);
    vec_t r;
    r.mode = m; r.patt = p; r.mask = k; r.base = b; r.num = n; r.rnd = rnd;
    r.cor = cor; r.cor_all = cor_all; r.cor_addr = ca; r.drop = drop;
    r.e_pass = ep; r.e_fail = ef; r.e_to = et; r.e_err = ee; r.e_first = efa;
    return r;
  endfunction

  function automatic logic [31:0] tb_lfsr_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  function automatic logic [31:0] exp_pat(input vec_t c, input logic [23:0] a, input logic [31:0] l);
    case (c.mode)
      2'd0:    return c.patt;
      2'd1:    return {8'h00, a};
      2'd2:    return ~{8'h00, a};
      default: return l;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".wr_en"}, 32'(wr_en), 32'd0);
    check({tag, ".rd_en"}, 32'(rd_en), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".pass"}, 32'(pass), 32'd0);
    check({tag, ".fail"}, 32'(fail), 32'd0);
    check({tag, ".timeout"}, 32'(timeout), 32'd0);
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'd0);
    check({tag, ".first_err_addr"}, 32'(first_err_addr), 32'd0);
    check({tag, ".wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, ".wr_data"}, wr_data, 32'd0);
    check({tag, ".rd_addr"}, 32'(rd_addr), 32'd0);
  endtask

  // Memory model, evaluated on the falling edge for the next rising edge.
  task automatic model_step();
    logic [23:0] a;
    logic [31:0] d;
    rd_data_valid = 1'b0;
    rd_data = '0;
    if (rq.size() != 0) begin
      a = rq.pop_front();
      if (!(cfg.drop && rtn_n == int'(cfg.num) - 1)) begin
        d = mem.exists(a) ? mem[a] : 32'h0;
        if (cfg.cor && (cfg.cor_all || a == cfg.cor_addr)) d = d ^ 32'h10;
        rd_data = d;
        rd_data_valid = 1'b1;
      end
      rtn_n++;
    end
    wr_rdy = cfg.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    rd_rdy = cfg.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    if (wr_en && wr_rdy) begin
      a = cfg.base + 24'(wr_n);
      check("wr_addr", 32'(wr_addr), 32'(a));
      check("wr_data", wr_data, exp_pat(cfg, a, m_lfsr));
      mem[wr_addr] = wr_data;
      m_lfsr = tb_lfsr_step(m_lfsr);
      wr_n++;
    end
    if (rd_en && rd_rdy) begin
      a = cfg.base + 24'(rd_n);
      check("rd_addr", 32'(rd_addr), 32'(a));
      rq.push_back(rd_addr);
      rd_n++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic start_vec(input vec_t t);
    cfg = t;
    wr_n = 0; rd_n = 0; rtn_n = 0;
    rq.delete();
    mem.delete();
    m_lfsr = (t.patt == 32'h0) ? 32'd1 : t.patt;
    mode = t.mode; patt = t.patt; cmp_mask = t.mask;
    base_addr = t.base; num_words = t.num;
    start = 1'b1;
    tick();
    start = 1'b0;
    // Scramble inputs: the engine must run on its latched copies.
    mode = ~t.mode; patt = ~t.patt; cmp_mask = '0;
    base_addr = ~t.base; num_words = t.num + 24'd5;
    if (t.num != 24'd0) begin
      check("busy_after_start", 32'(busy), 32'd1);
      check("done_cleared", 32'(done), 32'd0);
    end else begin
      check("busy_zero_len", 32'(busy), 32'd0);
    end
  endtask

  task automatic wait_done(input vec_t t);
    int n;
    for (n = 0; n < 6000 && done !== 1'b1; n++) tick();
    check("done", 32'(done), 32'd1);
    check("busy_end", 32'(busy), 32'd0);
    check("pass", 32'(pass), 32'(t.e_pass));
    check("fail", 32'(fail), 32'(t.e_fail));
    check("timeout", 32'(timeout), 32'(t.e_to));
    check("err_cnt", 32'(err_cnt), 32'(t.e_err));
    check("first_err_addr", 32'(first_err_addr), 32'(t.e_first));
    check("wr_beats", 32'(wr_n), 32'(t.num));
    check("rd_beats", 32'(rd_n), 32'(t.num));
    check("wr_en_end", 32'(wr_en), 32'd0);
    check("rd_en_end", 32'(rd_en), 32'd0);
    if (t.drop) check("timeout_delay", 32'(n >= int'(TIMEOUT)), 32'd1);
  endtask

  initial begin
    vecs[0] = mk(2'd0, 32'h00FFFFFF, 32'h00FFFFFF, 24'd0, 24'd503, 0, 0, 0, 24'd0, 0, 1, 0, 0, 16'd0, 24'd0);
    vecs[1] = mk(2'd1, 32'h0, 32'hFFFFFFFF, 24'd10, 24'd8, 0, 1, 0, 24'd13, 0, 0, 1, 0, 16'd1, 24'd13);
    vecs[2] = mk(2'd1, 32'h0, 32'hFFFFFFEF, 24'd10, 24'd8, 0, 1, 0, 24'd13, 0, 1, 0, 0, 16'd0, 24'd0);
    vecs[3] = mk(2'd3, 32'h0, 32'hFFFFFFFF, 24'd40, 24'd16, 1, 0, 0, 24'd0, 0, 1, 0, 0, 16'd0, 24'd0);
    vecs[4] = mk(2'd1, 32'h0, 32'hFFFFFFFF, 24'hFFFFFE, 24'd4, 0, 0, 0, 24'd0, 0, 1, 0, 0, 16'd0, 24'd0);
    vecs[5] = mk(2'd2, 32'h0, 32'hFFFFFFFF, 24'hFFFFFE, 24'd4, 0, 1, 0, 24'hFFFFFF, 0, 0, 1, 0, 16'd1, 24'hFFFFFF);
    vecs[6] = mk(2'd3, 32'h1234ABCD, 32'hFFFFFFFF, 24'd100, 24'd12, 1, 1, 0, 24'd105, 0, 0, 1, 0, 16'd1, 24'd105);
    vecs[7] = mk(2'd0, 32'h0, 32'hFFFFFFFF, 24'd5, 24'd0, 0, 0, 0, 24'd0, 0, 1, 0, 0, 16'd0, 24'd0);
    vecs[8] = mk(2'd1, 32'h0, 32'hFFFFFFFF, 24'd0, 24'd4, 0, 0, 0, 24'd0, 1, 0, 1, 1, 16'd0, 24'd0);
    vecs[9] = mk(2'd0, 32'hA5A5A5A5, 32'hFFFFFFFF, 24'd200, 24'd6, 0, 1, 1, 24'd0, 0, 0, 1, 0, 16'd6, 24'd200);
    cfg = vecs[7];
    wr_n = 0; rd_n = 0; rtn_n = 0; m_lfsr = 32'd1;

    #3;
    check_zero("reset");
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_zero("idle");

    for (int i = 0; i < NV; i++) begin
      start_vec(vecs[i]);
      wait_done(vecs[i]);
    end

    // A second start while busy must not restart or reconfigure the test.
    v = mk(2'd1, 32'h0, 32'hFFFFFFFF, 24'd300, 24'd50, 0, 0, 0, 24'd0, 0, 1, 0, 0, 16'd0, 24'd0);
    start_vec(v);
    repeat (10) tick();
    mode = 2'd0; base_addr = 24'd0; num_words = 24'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_ignore_start", 32'(busy), 32'd1);
    wait_done(v);

    // Asynchronous abort in the middle of the write phase.
    v = mk(2'd0, 32'h5A5A5A5A, 32'hFFFFFFFF, 24'd1000, 24'd100, 0, 0, 0, 24'd0, 0, 1, 0, 0, 16'd0, 24'd0);
    start_vec(v);
    repeat (5) tick();
    check("mid_write.wr_en", 32'(wr_en), 32'd1);
    check("mid_write.busy", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    check_zero("abort");
    tick();
    reset = 1'b0;
    tick();
    check_zero("post_abort");

    v = mk(2'd2, 32'h0, 32'hFFFFFFFF, 24'd7, 24'd3, 0, 0, 0, 24'd0, 0, 1, 0, 0, 16'd0, 24'd0);
    start_vec(v);
    wait_done(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
